// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro feedback path: FSM state encoding, default V2pi, FSM helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gyro_pkg;

    // Feedback controller state encoding (visible on o_state)
    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } state_e;

    // V2pi amplitude used until the first non-zero request is loaded
    localparam int V2PI_RST_DEF = 5000;

    // Next-state function. Dropping fb_on wins over a same-cycle trigger.
    function automatic state_e fsm_next(input state_e cur, input logic fb_on, input logic trig);
        state_e nxt;
        nxt = cur;
        case (cur)
            ST_OFF:  if (fb_on) nxt = ST_ARM;
            ST_ARM:  if (!fb_on) nxt = ST_OFF; else if (trig) nxt = ST_RUN;
            ST_RUN:  if (!fb_on) nxt = ST_OFF;
            default: nxt = ST_OFF;
        endcase
        return nxt;
    endfunction

    // True when this cycle performs a ladder/ramp update
    function automatic logic upd_fire(input state_e cur, input logic fb_on, input logic trig);
        return ((cur == ST_ARM) || (cur == ST_RUN)) && fb_on && trig;
    endfunction

endpackage

// File: rtl/sat_signed.sv
// Saturating signed truncation IN_W -> OUT_W with a clamp flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_val (IN_W signed) in; o_val (OUT_W signed) out; o_sat out, high when i_val was clamped.
module sat_signed #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    // Representable range of the narrow type, expressed at the wide width
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        o_val = i_val[OUT_W-1:0];
        o_sat = 1'b0;
        if (i_val > MAX_V) begin
            o_val = MAX_V[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (i_val < MIN_V) begin
            o_val = MIN_V[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/phase_ramp_ctrl.sv
// Serrodyne phase-ramp controller: integrates loop step into a 2pi-reset ladder, adds bias mod for the DAC.
// Latency: 1 cycle from i_trig to updated outputs and o_valid / wrap / clamp pulses.
// Backpressure: none; every trigger is consumed, back-to-back triggers give one update per cycle.
// Ports: i_clk, i_rst_n (async active-low); i_trig, i_step, i_v2pi, i_fb_on, i_mod, i_cnt_clr in;
//        o_ladderWave, o_phaseRamp, o_valid, o_wrap_p, o_wrap_n, o_wrap_cnt, o_step_clamp, o_sat, o_state out.
module phase_ramp_ctrl
    import gyro_pkg::*;
#(
    parameter int OUTPUT_BIT = 16,
    parameter int ACC_BIT    = 32,
    parameter int CNT_BIT    = 24,
    parameter int V2PI_RST   = V2PI_RST_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_trig,
    input  logic signed [ACC_BIT-1:0]    i_step,
    input  logic        [ACC_BIT-1:0]    i_v2pi,
    input  logic                         i_fb_on,
    input  logic signed [OUTPUT_BIT-1:0] i_mod,
    input  logic                         i_cnt_clr,
    output logic signed [OUTPUT_BIT-1:0] o_ladderWave,
    output logic signed [OUTPUT_BIT-1:0] o_phaseRamp,
    output logic                         o_valid,
    output logic                         o_wrap_p,
    output logic                         o_wrap_n,
    output logic signed [CNT_BIT-1:0]    o_wrap_cnt,
    output logic                         o_step_clamp,
    output logic                         o_sat,
    output logic [1:0]                   o_state
);

    // One guard bit over the accumulator so L + step and the 2*V2pi terms never overflow
    localparam int W = ACC_BIT + 1;
    typedef logic signed [W-1:0] acc_t;

    state_e                       state_q, state_d;
    acc_t                         ladder_q, ladder_d;
    logic        [ACC_BIT-1:0]    v2pi_q, v2pi_d;
    logic signed [OUTPUT_BIT-1:0] lad_out_q, lad_out_d;
    logic signed [OUTPUT_BIT-1:0] ramp_out_q, ramp_out_d;
    logic                         valid_q, valid_d;
    logic                         wrap_p_q, wrap_p_d;
    logic                         wrap_n_q, wrap_n_d;
    logic                         clamp_q, clamp_d;
    logic                         sat_q, sat_d;
    logic signed [CNT_BIT-1:0]    cnt_q, cnt_d;

    // Datapath uses the currently active V2pi; a new request only takes effect after the trigger
    acc_t v2pi_s, v2pi_2x, v2pi_neg, lim, lim_neg;
    acc_t step_x, stepc, sum, lad_next, ramp_raw, ramp_w;
    logic step_clamped, step_pos, step_neg, wp_c, wn_c;
    logic signed [OUTPUT_BIT-1:0] lad_sat, ramp_sat;
    logic lad_sat_f, ramp_sat_f;
    logic upd;

    assign v2pi_s   = $signed({1'b0, v2pi_q});
    assign v2pi_2x  = v2pi_s <<< 1;
    assign v2pi_neg = -v2pi_s;
    assign lim      = v2pi_s - acc_t'(1);
    assign lim_neg  = -lim;
    assign step_x   = acc_t'(i_step);

    // Symmetric step clamp to +/-(V2pi-1) so a single wrap always brings L back in range
    always_comb begin
        stepc        = step_x;
        step_clamped = 1'b0;
        if (step_x > lim) begin
            stepc        = lim;
            step_clamped = 1'b1;
        end else if (step_x < lim_neg) begin
            stepc        = lim_neg;
            step_clamped = 1'b1;
        end
    end

    assign step_pos = !stepc[W-1] && (stepc != '0);
    assign step_neg = stepc[W-1];
    assign sum      = ladder_q + stepc;

    // Ladder 2pi reset: the wrap direction follows the step sign, so a zero step never wraps
    always_comb begin
        lad_next = sum;
        wp_c     = 1'b0;
        wn_c     = 1'b0;
        if (step_pos && (sum >= v2pi_s)) begin
            lad_next = sum - v2pi_2x;
            wp_c     = 1'b1;
        end else if (step_neg && (sum <= v2pi_neg)) begin
            lad_next = sum + v2pi_2x;
            wn_c     = 1'b1;
        end
    end

    // Ramp is built from the pre-update ladder; its wrap is symmetric and independent of step
    assign ramp_raw = ladder_q + acc_t'(i_mod);

    always_comb begin
        ramp_w = ramp_raw;
        if (ramp_raw > v2pi_s) begin
            ramp_w = ramp_raw - v2pi_2x;
        end else if (ramp_raw < v2pi_neg) begin
            ramp_w = ramp_raw + v2pi_2x;
        end
    end

    sat_signed #(.IN_W(W), .OUT_W(OUTPUT_BIT)) u_sat_ladder (
        .i_val (lad_next),
        .o_val (lad_sat),
        .o_sat (lad_sat_f)
    );

    sat_signed #(.IN_W(W), .OUT_W(OUTPUT_BIT)) u_sat_ramp (
        .i_val (ramp_w),
        .o_val (ramp_sat),
        .o_sat (ramp_sat_f)
    );

    assign upd = upd_fire(state_q, i_fb_on, i_trig);

    always_comb begin
        state_d    = fsm_next(state_q, i_fb_on, i_trig);
        ladder_d   = ladder_q;
        v2pi_d     = v2pi_q;
        lad_out_d  = lad_out_q;
        ramp_out_d = ramp_out_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;
        wrap_p_d   = 1'b0;
        wrap_n_d   = 1'b0;
        clamp_d    = 1'b0;

        if (upd) begin
            ladder_d   = lad_next;
            lad_out_d  = lad_sat;
            ramp_out_d = ramp_sat;
            sat_d      = lad_sat_f | ramp_sat_f;
            valid_d    = 1'b1;
            wrap_p_d   = wp_c;
            wrap_n_d   = wn_c;
            clamp_d    = step_clamped;
        end else if ((state_q == ST_OFF) || !i_fb_on) begin
            // OFF, or leaving ARM/RUN: ladder parked at zero, ramp follows the bias modulation
            ladder_d   = '0;
            lad_out_d  = '0;
            ramp_out_d = i_mod;
            sat_d      = 1'b0;
        end else if (state_q == ST_ARM) begin
            ramp_out_d = i_mod;
        end

        // V2pi tracks the request freely while OFF, only at trigger instants otherwise; zero means keep
        if (((state_q == ST_OFF) || i_trig) && (i_v2pi != '0)) begin
            v2pi_d = i_v2pi;
        end

        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (wrap_p_d) begin
            cnt_d = cnt_q + CNT_BIT'(1);
        end else if (wrap_n_d) begin
            cnt_d = cnt_q - CNT_BIT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_OFF;
            ladder_q   <= '0;
            v2pi_q     <= ACC_BIT'(V2PI_RST);
            lad_out_q  <= '0;
            ramp_out_q <= '0;
            valid_q    <= 1'b0;
            wrap_p_q   <= 1'b0;
            wrap_n_q   <= 1'b0;
            clamp_q    <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ladder_q   <= ladder_d;
            v2pi_q     <= v2pi_d;
            lad_out_q  <= lad_out_d;
            ramp_out_q <= ramp_out_d;
            valid_q    <= valid_d;
            wrap_p_q   <= wrap_p_d;
            wrap_n_q   <= wrap_n_d;
            clamp_q    <= clamp_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_ladderWave = lad_out_q;
    assign o_phaseRamp  = ramp_out_q;
    assign o_valid      = valid_q;
    assign o_wrap_p     = wrap_p_q;
    assign o_wrap_n     = wrap_n_q;
    assign o_wrap_cnt   = cnt_q;
    assign o_step_clamp = clamp_q;
    assign o_sat        = sat_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_phase_ramp_ctrl.sv
// Directed self-checking bench for phase_ramp_ctrl (default widths plus a 12-bit output instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_phase_ramp_ctrl;

    localparam int OB = 16;
    localparam int AB = 32;
    localparam int CB = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance (OUTPUT_BIT = 16)
    logic                 trig, fb_on, cnt_clr;
    logic signed [AB-1:0] step;
    logic        [AB-1:0] v2pi;
    logic signed [OB-1:0] mod;
    logic signed [OB-1:0] ladder, ramp;
    logic                 valid, wrap_p, wrap_n, step_clamp, sat;
    logic signed [CB-1:0] wrap_cnt;
    logic [1:0]           state;

    // Narrow instance (OUTPUT_BIT = 12)
    logic                 b_trig, b_fb_on, b_cnt_clr;
    logic signed [AB-1:0] b_step;
    logic        [AB-1:0] b_v2pi;
    logic signed [11:0]   b_mod;
    logic signed [11:0]   b_ladder, b_ramp;
    logic                 b_valid, b_wrap_p, b_wrap_n, b_step_clamp, b_sat;
    logic signed [CB-1:0] b_wrap_cnt;
    logic [1:0]           b_state;

    int n_checks = 0;
    int n_fail   = 0;

    phase_ramp_ctrl #(.OUTPUT_BIT(OB), .ACC_BIT(AB), .CNT_BIT(CB), .V2PI_RST(5000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_step(step), .i_v2pi(v2pi),
        .i_fb_on(fb_on), .i_mod(mod), .i_cnt_clr(cnt_clr),
        .o_ladderWave(ladder), .o_phaseRamp(ramp), .o_valid(valid), .o_wrap_p(wrap_p),
        .o_wrap_n(wrap_n), .o_wrap_cnt(wrap_cnt), .o_step_clamp(step_clamp), .o_sat(sat),
        .o_state(state)
    );

    phase_ramp_ctrl #(.OUTPUT_BIT(12), .ACC_BIT(AB), .CNT_BIT(CB), .V2PI_RST(5000)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(b_trig), .i_step(b_step), .i_v2pi(b_v2pi),
        .i_fb_on(b_fb_on), .i_mod(b_mod), .i_cnt_clr(b_cnt_clr),
        .o_ladderWave(b_ladder), .o_phaseRamp(b_ramp), .o_valid(b_valid), .o_wrap_p(b_wrap_p),
        .o_wrap_n(b_wrap_n), .o_wrap_cnt(b_wrap_cnt), .o_step_clamp(b_step_clamp), .o_sat(b_sat),
        .o_state(b_state)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig_once();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (ladder !== 0)   begin n_fail++; $display("FAIL rst_ladder: got %0d expected 0", ladder); end
        n_checks++; if (ramp !== 0)     begin n_fail++; $display("FAIL rst_ramp: got %0d expected 0", ramp); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
        n_checks++; if (wrap_cnt !== 0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", wrap_cnt); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", valid); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (ramp !== 1250)  begin n_fail++; $display("FAIL off_ramp: got %0d expected 1250", ramp); end
        n_checks++; if (ladder !== 0)   begin n_fail++; $display("FAIL off_ladder: got %0d expected 0", ladder); end
        tick();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL off_state: got %0d expected 0", state); end
    endtask

    task automatic test_up_ramp();
        int exp_l[6]  = '{1000, 2000, 3000, 4000, -5000, -4000};
        int exp_r[6]  = '{0, 1000, 2000, 3000, 4000, -5000};
        bit exp_wp[6] = '{0, 0, 0, 0, 1, 0};
        mod = 0; step = 1000; v2pi = 5000; fb_on = 1'b1;
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL arm_state: got %0d expected 1", state); end
        for (int i = 0; i < 6; i++) begin
            trig_once();
            n_checks++; if (ladder !== exp_l[i]) begin n_fail++; $display("FAIL up_ladder[%0d]: got %0d expected %0d", i, ladder, exp_l[i]); end
            n_checks++; if (ramp !== exp_r[i])   begin n_fail++; $display("FAIL up_ramp[%0d]: got %0d expected %0d", i, ramp, exp_r[i]); end
            n_checks++; if (wrap_p !== exp_wp[i]) begin n_fail++; $display("FAIL up_wrap_p[%0d]: got %0b expected %0b", i, wrap_p, exp_wp[i]); end
            n_checks++; if (valid !== 1'b1)      begin n_fail++; $display("FAIL up_valid[%0d]: got %0b expected 1", i, valid); end
        end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL run_state: got %0d expected 2", state); end
        n_checks++; if (wrap_cnt !== 1) begin n_fail++; $display("FAIL up_cnt: got %0d expected 1", wrap_cnt); end
        n_checks++; if (sat !== 1'b0)   begin n_fail++; $display("FAIL up_sat: got %0b expected 0", sat); end
        tick();
        n_checks++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL hold_valid: got %0b expected 0", valid); end
        n_checks++; if (ladder !== -4000) begin n_fail++; $display("FAIL hold_ladder: got %0d expected -4000", ladder); end
    endtask

    task automatic test_down_ramp();
        fb_on = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_checks++; if (wrap_cnt !== 0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", wrap_cnt); end
        n_checks++; if (ladder !== 0)   begin n_fail++; $display("FAIL off_zero: got %0d expected 0", ladder); end
        fb_on = 1'b1; step = -3000;
        tick();
        trig_once();
        n_checks++; if (ladder !== -3000) begin n_fail++; $display("FAIL dn_ladder0: got %0d expected -3000", ladder); end
        n_checks++; if (valid !== 1'b1)   begin n_fail++; $display("FAIL dn_valid: got %0b expected 1", valid); end
        n_checks++; if (wrap_n !== 1'b0)  begin n_fail++; $display("FAIL dn_wrap_n0: got %0b expected 0", wrap_n); end
        tick();
        n_checks++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL dn_valid_gap: got %0b expected 0", valid); end
        trig_once();
        n_checks++; if (ladder !== 4000)  begin n_fail++; $display("FAIL dn_ladder1: got %0d expected 4000", ladder); end
        n_checks++; if (wrap_n !== 1'b1)  begin n_fail++; $display("FAIL dn_wrap_n1: got %0b expected 1", wrap_n); end
        n_checks++; if (wrap_p !== 1'b0)  begin n_fail++; $display("FAIL dn_wrap_p1: got %0b expected 0", wrap_p); end
        n_checks++; if (wrap_cnt !== -1)  begin n_fail++; $display("FAIL dn_cnt: got %0d expected -1", wrap_cnt); end
    endtask

    task automatic test_ramp_wrap();
        step = 0; mod = 1250;
        trig_once();
        n_checks++; if (ramp !== -4750)  begin n_fail++; $display("FAIL rw_pos_ramp: got %0d expected -4750", ramp); end
        n_checks++; if (ladder !== 4000) begin n_fail++; $display("FAIL rw_hold_ladder: got %0d expected 4000", ladder); end
        n_checks++; if ((wrap_p | wrap_n) !== 1'b0) begin n_fail++; $display("FAIL rw_no_wrap: got %0b expected 0", wrap_p | wrap_n); end
        step = -4000; mod = 0;
        trig_once();
        trig_once();
        n_checks++; if (ladder !== -4000) begin n_fail++; $display("FAIL rw_ladder: got %0d expected -4000", ladder); end
        step = 0; mod = -1250;
        trig_once();
        n_checks++; if (ramp !== 4750)   begin n_fail++; $display("FAIL rw_neg_ramp: got %0d expected 4750", ramp); end
        mod = 0;
    endtask

    task automatic test_clamp_v2pi();
        step = 7000;
        trig_once();
        n_checks++; if (ladder !== 999)      begin n_fail++; $display("FAIL cl_ladder: got %0d expected 999", ladder); end
        n_checks++; if (step_clamp !== 1'b1) begin n_fail++; $display("FAIL cl_flag: got %0b expected 1", step_clamp); end
        tick();
        n_checks++; if (step_clamp !== 1'b0) begin n_fail++; $display("FAIL cl_flag_pulse: got %0b expected 0", step_clamp); end
        v2pi = 6000;
        tick();
        trig_once();
        n_checks++; if (ladder !== -4002)    begin n_fail++; $display("FAIL v2pi_old_ladder: got %0d expected -4002", ladder); end
        n_checks++; if (wrap_p !== 1'b1)     begin n_fail++; $display("FAIL v2pi_old_wrap: got %0b expected 1", wrap_p); end
        trig_once();
        n_checks++; if (ladder !== 1997)     begin n_fail++; $display("FAIL v2pi_new_ladder: got %0d expected 1997", ladder); end
        n_checks++; if (step_clamp !== 1'b1) begin n_fail++; $display("FAIL v2pi_new_clamp: got %0b expected 1", step_clamp); end
        n_checks++; if (wrap_cnt !== 0)      begin n_fail++; $display("FAIL cl_cnt: got %0d expected 0", wrap_cnt); end
    endtask

    task automatic test_back_to_back();
        step = 1000;
        trig = 1'b1;
        tick();
        n_checks++; if (ladder !== 2997) begin n_fail++; $display("FAIL b2b_0: got %0d expected 2997", ladder); end
        n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL b2b_valid0: got %0b expected 1", valid); end
        tick();
        trig = 1'b0;
        n_checks++; if (ladder !== 3997) begin n_fail++; $display("FAIL b2b_1: got %0d expected 3997", ladder); end
        n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL b2b_valid1: got %0b expected 1", valid); end
        tick();
        n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL b2b_valid2: got %0b expected 0", valid); end
    endtask

    task automatic test_drop_with_trig();
        fb_on = 1'b0; trig = 1'b1; mod = 300;
        tick();
        trig = 1'b0;
        n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL drop_valid: got %0b expected 0", valid); end
        n_checks++; if (state !== 2'd0)  begin n_fail++; $display("FAIL drop_state: got %0d expected 0", state); end
        n_checks++; if (ladder !== 0)    begin n_fail++; $display("FAIL drop_ladder: got %0d expected 0", ladder); end
        n_checks++; if (ramp !== 300)    begin n_fail++; $display("FAIL drop_ramp: got %0d expected 300", ramp); end
        mod = -700;
        tick();
        n_checks++; if (ramp !== -700)   begin n_fail++; $display("FAIL off_track: got %0d expected -700", ramp); end
        fb_on = 1'b1;
        tick();
        mod = 900;
        tick();
        n_checks++; if (ramp !== 900)    begin n_fail++; $display("FAIL arm_track: got %0d expected 900", ramp); end
        n_checks++; if (state !== 2'd1)  begin n_fail++; $display("FAIL arm_state2: got %0d expected 1", state); end
    endtask

    task automatic test_reset_midrun();
        step = 1000;
        trig_once();
        n_checks++; if (ladder !== 1000) begin n_fail++; $display("FAIL mr_ladder: got %0d expected 1000", ladder); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ladder !== 0)    begin n_fail++; $display("FAIL mr_rst_ladder: got %0d expected 0", ladder); end
        n_checks++; if (ramp !== 0)      begin n_fail++; $display("FAIL mr_rst_ramp: got %0d expected 0", ramp); end
        n_checks++; if (state !== 2'd0)  begin n_fail++; $display("FAIL mr_rst_state: got %0d expected 0", state); end
        v2pi = 0; fb_on = 1'b1; step = 7000; mod = 0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (state !== 2'd0)  begin n_fail++; $display("FAIL mr_rel_state: got %0d expected 0", state); end
        tick();
        n_checks++; if (state !== 2'd1)  begin n_fail++; $display("FAIL mr_arm_state: got %0d expected 1", state); end
        trig_once();
        n_checks++; if (ladder !== 4999) begin n_fail++; $display("FAIL mr_v2pi_rst: got %0d expected 4999", ladder); end
        n_checks++; if (step_clamp !== 1'b1) begin n_fail++; $display("FAIL mr_clamp: got %0b expected 1", step_clamp); end
    endtask

    task automatic test_sat12();
        b_fb_on = 1'b1;
        tick();
        b_step = 2500; b_mod = 0; b_trig = 1'b1;
        tick();
        b_trig = 1'b0;
        n_checks++; if (b_ladder !== 2047) begin n_fail++; $display("FAIL s12_ladder: got %0d expected 2047", b_ladder); end
        n_checks++; if (b_sat !== 1'b1)    begin n_fail++; $display("FAIL s12_sat0: got %0b expected 1", b_sat); end
        n_checks++; if (b_valid !== 1'b1)  begin n_fail++; $display("FAIL s12_valid: got %0b expected 1", b_valid); end
        b_step = 0; b_mod = 400; b_trig = 1'b1;
        tick();
        b_trig = 1'b0;
        n_checks++; if (b_ramp !== 2047)   begin n_fail++; $display("FAIL s12_ramp: got %0d expected 2047", b_ramp); end
        n_checks++; if (b_sat !== 1'b1)    begin n_fail++; $display("FAIL s12_sat1: got %0b expected 1", b_sat); end
        b_fb_on = 1'b0; b_trig = 1'b1;
        tick();
        b_trig = 1'b0;
        n_checks++; if (b_valid !== 1'b0)  begin n_fail++; $display("FAIL s12_drop_valid: got %0b expected 0", b_valid); end
        n_checks++; if (b_ladder !== 0)    begin n_fail++; $display("FAIL s12_drop_ladder: got %0d expected 0", b_ladder); end
        n_checks++; if (b_ramp !== 400)    begin n_fail++; $display("FAIL s12_drop_ramp: got %0d expected 400", b_ramp); end
        n_checks++; if (b_sat !== 1'b0)    begin n_fail++; $display("FAIL s12_drop_sat: got %0b expected 0", b_sat); end
    endtask

    initial begin
        rst_n = 1'b0;
        trig = 1'b0; fb_on = 1'b0; cnt_clr = 1'b0;
        step = 0; v2pi = 5000; mod = 1250;
        b_trig = 1'b0; b_fb_on = 1'b0; b_cnt_clr = 1'b0;
        b_step = 0; b_v2pi = 3000; b_mod = 0;

        test_reset();
        test_up_ramp();
        test_down_ramp();
        test_ramp_wrap();
        test_clamp_v2pi();
        test_back_to_back();
        test_drop_with_trig();
        test_reset_midrun();
        test_sat12();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
